// File: rtl/stall_pkg.sv
// stall_pkg: state encoding and counter-width helper shared by the pipeline stall controller.
package stall_pkg;
    typedef enum logic [1:0] {WARMUP, RUN, STALL, FORCE} state_e;
    // Width needed to hold 0..n, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction
endpackage

// File: rtl/warmup_counter.sv
// warmup_counter: loadable down-counter that saturates at zero; last flags the final counted cycle.
module warmup_counter #(
    parameter int W = 1,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         last
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load ? load_val : (dec && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt_q <= INIT;
        else cnt_q <= cnt_d;
    assign last = cnt_q == W'(1);
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: PC / IF-ID enable control with warm-up window, stall merge and flush priority.
// Define STALL_WATCHDOG_EN to add the forced-release watchdog and sticky stall_timeout flag.
module pipeline_stall_ctrl
    import stall_pkg::*;
#(
    parameter int WARMUP_CYCLES = 1,
    parameter int NUM_REQ = 2,
    parameter int MAX_STALL = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pc_en_in,
    input  logic [NUM_REQ-1:0] stall_req,
    input  logic               flush,
    output logic               pc_en,
    output logic               ifid_en,
    output logic               ifid_flush,
    output logic               ctrl_valid,
    output logic               stall_active,
    output logic               stall_timeout
);
    localparam int WW = cnt_w(WARMUP_CYCLES);
    localparam state_e RST_STATE = (WARMUP_CYCLES == 0) ? RUN : WARMUP;

    if (NUM_REQ < 1 || MAX_STALL < 2) begin : g_bad_params
        $error("pipeline_stall_ctrl: NUM_REQ must be >= 1 and MAX_STALL >= 2");
    end

    state_e state_q, state_d;
    logic   warm, warm_last, stall_eff, go, wd_fire;

    warmup_counter #(.W(WW), .INIT(WW'(WARMUP_CYCLES))) u_warm (
        .clk     (clk),
        .reset   (reset),
        .load    (1'b0),
        .load_val('0),
        .dec     (warm),
        .last    (warm_last)
    );

    // FORCE masks the stall for one cycle so the pipeline advances once.
    always_comb begin
        warm         = state_q == WARMUP;
        stall_eff    = |stall_req && state_q != FORCE;
        go           = |stall_req && !flush;
        stall_active = !warm && !flush && stall_eff;
        pc_en        = warm || flush || (!stall_eff && pc_en_in);
        ifid_en      = !stall_active;
        ifid_flush   = !warm && flush;
        ctrl_valid   = !warm;
        state_d      = warm ? (warm_last ? RUN : WARMUP) : !go ? RUN : wd_fire ? FORCE : STALL;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) state_q <= RST_STATE;
        else state_q <= state_d;

`ifdef STALL_WATCHDOG_EN
    localparam int SW = cnt_w(MAX_STALL);
    logic [SW-1:0] stall_cnt_q, stall_cnt_d;
    logic          timeout_q, timeout_d;
    always_comb begin
        wd_fire     = state_q == STALL && stall_cnt_q == SW'(MAX_STALL - 1);
        stall_cnt_d = stall_active ? stall_cnt_q + 1'b1 : '0;
        timeout_d   = timeout_q || state_d == FORCE;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    assign stall_timeout = timeout_q;
`else
    assign wd_fire       = 1'b0;
    assign stall_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: scoreboard bench for pipeline_stall_ctrl (WARMUP_CYCLES=2, MAX_STALL=4).
module tb_pipeline_stall_ctrl;
    localparam int WARM = 2;
    localparam int MAXS = 4;

    typedef struct packed {
        logic pc, ien, ifl, cv, sact, to;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, pc_en_in, flush;
    logic [1:0] stall_req;
    logic       pc_en, ifid_en, ifid_flush, ctrl_valid, stall_active, stall_timeout;

    int   n_chk = 0, n_err = 0;
    exp_t sb[$];
    int   m_warm, m_sc;
    bit   m_force, m_to;

    pipeline_stall_ctrl #(.WARMUP_CYCLES(WARM), .NUM_REQ(2), .MAX_STALL(MAXS)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_en_in     (pc_en_in),
        .stall_req    (stall_req),
        .flush        (flush),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .ifid_flush   (ifid_flush),
        .ctrl_valid   (ctrl_valid),
        .stall_active (stall_active),
        .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, want);
        end
    endtask

    task automatic m_reset();
        m_warm  = WARM;
        m_sc    = 0;
        m_force = 0;
        m_to    = 0;
    endtask

    function automatic exp_t model(input logic pin, input logic [1:0] req, input logic fl);
        exp_t e;
        bit   sa;
        sa = (req != 2'b00) && !m_force;
        e.to = m_to;
        if (m_warm > 0) begin
            e.pc = 1; e.ien = 1; e.ifl = 0; e.sact = 0; e.cv = 0;
        end else begin
            e.cv = 1;
            if (fl) begin
                e.pc = 1; e.ien = 1; e.ifl = 1; e.sact = 0;
            end else if (sa) begin
                e.pc = 0; e.ien = 0; e.ifl = 0; e.sact = 1;
            end else begin
                e.pc = pin; e.ien = 1; e.ifl = 0; e.sact = 0;
            end
        end
        return e;
    endfunction

    task automatic advance(input logic stalled);
        if (m_warm > 0) m_warm--;
        else if (stalled) begin
            m_sc++;
            m_force = 0;
`ifdef STALL_WATCHDOG_EN
            if (m_sc == MAXS) begin
                m_force = 1;
                m_sc    = 0;
                m_to    = 1;
            end
`endif
        end else begin
            m_sc    = 0;
            m_force = 0;
        end
    endtask

    task automatic cyc(input logic pin, input logic [1:0] req, input logic fl);
        exp_t g;
        pc_en_in  = pin;
        stall_req = req;
        flush     = fl;
        sb.push_back(model(pin, req, fl));
        @(negedge clk);
        g = sb.pop_front();
        chk("pc_en", pc_en, g.pc);
        chk("ifid_en", ifid_en, g.ien);
        chk("ifid_flush", ifid_flush, g.ifl);
        chk("ctrl_valid", ctrl_valid, g.cv);
        chk("stall_active", stall_active, g.sact);
        chk("stall_timeout", stall_timeout, g.to);
        advance(g.sact);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pc_en"}, pc_en, 1'b1);
        chk({tag, "_ifid_en"}, ifid_en, 1'b1);
        chk({tag, "_ifid_flush"}, ifid_flush, 1'b0);
        chk({tag, "_ctrl_valid"}, ctrl_valid, 1'b0);
        chk({tag, "_stall_active"}, stall_active, 1'b0);
        chk({tag, "_stall_timeout"}, stall_timeout, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        pc_en_in  = 1'bx;
        stall_req = 2'b00;
        flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        reset = 1'b0;
        m_reset();
        cyc(1'bx, 2'b00, 1'b0);
        cyc(1'bx, 2'b11, 1'b1);
        cyc(1'b0, 2'b00, 1'b0);
        cyc(1'b1, 2'b00, 1'b0);
        cyc(1'b0, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 2'b10, 1'b0);
        cyc(1'b1, 2'b00, 1'b0);
        cyc(1'b1, 2'b01, 1'b1);
        cyc(1'b0, 2'b00, 1'b0);
        cyc(1'b1, 2'b11, 1'b0);
        cyc(1'b1, 2'b11, 1'b1);
        cyc(1'b1, 2'b11, 1'b0);
        cyc(1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 40; i++) cyc(1'b1, 2'b10, 1'b0);
        cyc(1'b1, 2'b00, 1'b0);
        cyc(1'b0, 2'b00, 1'b0);
        for (int i = 0; i < 30; i++)
            cyc(1'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0));
        cyc(1'b1, 2'b00, 1'b0);
        cyc(1'b1, 2'b01, 1'b0);
        pc_en_in  = 1'b1;
        stall_req = 2'b01;
        flush     = 1'b0;
        #2;
        chk("midstall_active", stall_active, 1'b1);
        reset = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk);
        #1;
        chk_reset_outputs("midrst_hold");
        reset = 1'b0;
        m_reset();
        cyc(1'bx, 2'b01, 1'b0);
        cyc(1'bx, 2'b01, 1'b0);
        cyc(1'b1, 2'b00, 1'b0);
        cyc(1'b0, 2'b00, 1'b0);
        cyc(1'b1, 2'b10, 1'b0);
        cyc(1'b1, 2'b00, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
